// File: rtl/fdivsqrt_otfc_ctrl_pkg.sv
// fdivsqrt_otfc_ctrl_pkg: shared sizes, digit encoding and sequencer states for the OTFC controller
package fdivsqrt_otfc_ctrl_pkg;
    localparam int DIVB_DEFAULT  = 64;
    localparam int ITERW_DEFAULT = 7;
    typedef logic [3:0] udigit_t;
    localparam udigit_t DIG_P2 = 4'b1000;
    localparam udigit_t DIG_P1 = 4'b0100;
    localparam udigit_t DIG_M1 = 4'b0010;
    localparam udigit_t DIG_M2 = 4'b0001;
    localparam udigit_t DIG_Z  = 4'b0000;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/fdivsqrt_otfc_ctrl_uotfc.sv
// fdivsqrtuotfc4: radix-4 unified on-the-fly converter next-value logic for U/UM
module fdivsqrtuotfc4
    import fdivsqrt_otfc_ctrl_pkg::*;
#(
    parameter int DIVB = DIVB_DEFAULT
) (
    input  udigit_t         udigit,
    input  logic [DIVB:0]   u,
    input  logic [DIVB:0]   um,
    input  logic [DIVB:0]   c,
    output logic [DIVB:0]   un,
    output logic [DIVB:0]   umn
);
    logic [DIVB:0] c1, c2, k1, k2, k3;
    assign c1 = c << 1;
    assign c2 = c << 2;
    assign k1 = c & ~c1;
    assign k2 = c1 & ~c2;
    assign k3 = c & ~c2;
    // multi-hot digits resolve by priority +2 > +1 > -1 > -2
    assign un  = udigit[3] ? (u | k2) : udigit[2] ? (u | k1) : udigit[1] ? (um | k3) :
                 udigit[0] ? (um | k2) : u;
    assign umn = udigit[3] ? (u | k1) : udigit[2] ? u : udigit[1] ? (um | k2) :
                 udigit[0] ? (um | k1) : (um | k3);
endmodule

// File: rtl/fdivsqrt_otfc_ctrl.sv
// fdivsqrt_otfc_ctrl: sequences the radix-4 OTFC, owning U/UM/C, iteration count and handshake
module fdivsqrt_otfc_ctrl
    import fdivsqrt_otfc_ctrl_pkg::*;
#(
    parameter int DIVB  = DIVB_DEFAULT,
    parameter int ITERW = ITERW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sqrt_en,
    input  logic [ITERW-1:0] num_iter,
    input  logic             stall,
    input  logic             abort,
    input  udigit_t          udigit,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             last,
    output logic [DIVB:0]    u,
    output logic [DIVB:0]    um
);
    // C[1:0] never feed the next C, so only C[DIVB:2] is stored
    localparam logic [DIVB-2:0] C_HI_INIT = {2'b11, {(DIVB-3){1'b0}}};
    state_t            state, state_n;
    logic [DIVB-2:0]   c_hi;
    logic [DIVB:0]     cn, u_nx, um_nx;
    logic [ITERW-1:0]  cnt;
    logic              take, adv, fin;
    assign cn   = {2'b11, c_hi};
    assign take = (state == IDLE) && start;
    assign adv  = (state == BUSY) && !stall && !abort;
    assign fin  = cnt == ITERW'(1);
    assign last = adv && fin;
    assign busy = state == BUSY;
    assign done = state == DONE;
    fdivsqrtuotfc4 #(.DIVB(DIVB)) u_otfc (
        .udigit (udigit),
        .u      (u),
        .um     (um),
        .c      (cn),
        .un     (u_nx),
        .umn    (um_nx)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? ((num_iter != '0) ? BUSY : DONE) : IDLE;
            BUSY:    state_n = abort ? IDLE : last ? DONE : BUSY;
            DONE:    state_n = (abort || ack) ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            u     <= '0;
            um    <= '0;
            c_hi  <= C_HI_INIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                c_hi <= C_HI_INIT;
                u    <= sqrt_en ? {1'b1, {DIVB{1'b0}}} : '0;
                um   <= '0;
                cnt  <= num_iter;
            end else if (adv) begin
                u    <= u_nx;
                um   <= um_nx;
                c_hi <= cn[DIVB:2];
                cnt  <= cnt - ITERW'(1);
            end else if (abort && state != IDLE) begin
                cnt  <= '0;
            end
        end
    end
endmodule
